// File: rtl/uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// uart_cmd_wrapper
//
// Serial front end for the logic-analyzer command path. Two UART bytes from the
// host are assembled into a 16-bit command (first byte -> cmd[15:8]) and
// presented as cmd/cmd_rdy. Each 8-bit response from the command/config block
// is serialized back to the host on TX. Both directions use the bit period
// P = max(baud_cnt, MIN_BAUD), latched at the start of every frame.
//
// Optional feature macro: CMD_TIMEOUT_EN
//   When defined, a half-received command (byte phase LOW) is abandoned if no
//   new start bit arrives within TIMEOUT_CYCLES clocks of the first byte's
//   stop sample.
//
// Parameters:
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (CMD_TIMEOUT_EN only)
//   MIN_BAUD        minimum effective bit period in clk cycles
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   RX           asynchronous serial input from host, idle high
//   TX           serial output to host, idle high, driven from a flop
//   baud_cnt     clk cycles per bit ({baud_cntH, baud_cntL})
//   cmd          assembled 16-bit command
//   cmd_rdy      cmd valid level, held until cleared
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   resp         response byte to transmit
//   send_resp    one-cycle request to transmit resp
//   resp_sent    one-cycle pulse after the stop bit of resp completes
//   tx_busy      high from accepted send_resp until resp_sent
// -----------------------------------------------------------------------------
module uart_cmd_wrapper #(
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned MIN_BAUD       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] baud_cnt,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent,
    output logic        tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Half-period sampling needs P >= 2 and P must fit the 16-bit counters.
    if (MIN_BAUD < 2 || MIN_BAUD > 65535 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_cmd_wrapper: MIN_BAUD must be 2..65535 and TIMEOUT_CYCLES >= 1");
    end

    logic [15:0] eff_per;
    always_comb begin
        eff_per = (baud_cnt < 16'(MIN_BAUD)) ? 16'(MIN_BAUD) : baud_cnt;
    end

    // ------------------------------------------------------------------ RX ---
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic        rx_fall;

    state_t      rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_per_q, rx_per_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        phase_low_q, phase_low_d;
    logic [7:0]  cmd_hi_q, cmd_hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_per_d    = rx_per_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        phase_low_d = phase_low_q;
        cmd_hi_d    = cmd_hi_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q;

        // Acknowledge is applied first so a same-cycle load overrides it.
        if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end

        case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = 16'd0;
                    rx_per_d   = eff_per;
                    // A new command is starting, so the previous one is stale.
                    if (!phase_low_q) begin
                        cmd_rdy_d = 1'b0;
                    end
                end
            end
            S_START: begin
                if (rx_cnt_q == ((rx_per_q >> 1) - 16'd1)) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    // Line back high at mid-start: treat as a glitch.
                    rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == (rx_per_q - 16'd1)) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == (rx_per_q - 16'd1)) begin
                    rx_cnt_d   = 16'd0;
                    rx_state_d = S_IDLE;
                    if (!rx_s2_q) begin
                        // Framing error: drop the byte and resynchronize pairing.
                        phase_low_d = 1'b0;
                    end else if (phase_low_q) begin
                        cmd_d       = {cmd_hi_q, rx_shift_q};
                        cmd_rdy_d   = 1'b1;
                        phase_low_d = 1'b0;
                    end else begin
                        cmd_hi_d    = rx_shift_q;
                        phase_low_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase

`ifdef CMD_TIMEOUT_EN
        // Counts only while waiting between the two bytes of a command.
        to_cnt_d = '0;
        if (rx_state_q == S_IDLE && phase_low_q && !rx_fall) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                phase_low_d = 1'b0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= S_IDLE;
            rx_cnt_q    <= 16'd0;
            rx_bit_q    <= 3'd0;
            phase_low_q <= 1'b0;
            cmd_q       <= 16'd0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            phase_low_q <= phase_low_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
        end
        rx_per_q   <= rx_per_d;
        rx_shift_q <= rx_shift_d;
        cmd_hi_q   <= cmd_hi_d;
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------ TX ---
    state_t      tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_per_q, tx_per_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        tx_busy_q, tx_busy_d;
    logic        resp_sent_q, resp_sent_d;

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_per_d    = tx_per_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_d        = tx_q;
        tx_busy_d   = tx_busy_q;
        resp_sent_d = 1'b0;

        case (tx_state_q)
            S_IDLE: begin
                // Requests in the resp_sent cycle are dropped, not deferred.
                if (send_resp && !resp_sent_q) begin
                    tx_state_d = S_START;
                    tx_cnt_d   = 16'd0;
                    tx_per_d   = eff_per;
                    tx_shift_d = resp;
                    tx_busy_d  = 1'b1;
                    tx_d       = 1'b0;
                end
            end
            S_START: begin
                if (tx_cnt_q == (tx_per_q - 16'd1)) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = 16'd0;
                    tx_bit_d   = 3'd0;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == (tx_per_q - 16'd1)) begin
                    tx_cnt_d = 16'd0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == (tx_per_q - 16'd1)) begin
                    tx_state_d  = S_IDLE;
                    tx_cnt_d    = 16'd0;
                    tx_busy_d   = 1'b0;
                    resp_sent_d = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= 16'd0;
            tx_bit_q    <= 3'd0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            resp_sent_q <= resp_sent_d;
        end
        tx_per_q   <= tx_per_d;
        tx_shift_q <= tx_shift_d;
    end

    assign TX        = tx_q;
    assign tx_busy   = tx_busy_q;
    assign resp_sent = resp_sent_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_wrapper
//
// Directed bench for uart_cmd_wrapper. Host bytes are driven on RX at a fixed
// 16-cycle bit period, responses are observed on TX slot by slot. Expected
// values are hand-computed constants in the vector tables and sequences.
// Build with +define+CMD_TIMEOUT_EN to exercise the timeout variant.
// -----------------------------------------------------------------------------
module tb_uart_cmd_wrapper;

    localparam int P = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] baud_cnt;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;
    int sent_cnt = 0;

    uart_cmd_wrapper #(
        .TIMEOUT_CYCLES(1000),
        .MIN_BAUD      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (RX),
        .TX         (TX),
        .baud_cnt   (baud_cnt),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp       (resp),
        .send_resp  (send_resp),
        .resp_sent  (resp_sent),
        .tx_busy    (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resp_sent === 1'b1) sent_cnt <= sent_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] baud;
        logic [15:0] exp_cmd;
    } rx_vec_t;

    typedef struct {
        logic [7:0]  resp;
        logic [15:0] baud;
        logic [9:0]  exp_frame;  // bit j = TX level in slot j (start..stop)
    } tx_vec_t;

    rx_vec_t rxv[4];
    tx_vec_t txv[4];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One host frame; with chk, cmd_rdy must rise exactly 155 cycles after
    // the start bit is driven (3 cycles sync/edge + P/2 + 9P).
    task automatic send_byte(input logic [7:0] b, input logic stop_v,
                             input bit chk, input bit clr_at_load);
        RX = 1'b0;
        tick(P);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            tick(P);
        end
        RX = stop_v;
        if (chk) begin
            tick(10);
            check("rdy_before_load", cmd_rdy, 1'b0);
            if (clr_at_load) clr_cmd_rdy = 1'b1;
            tick(1);
            clr_cmd_rdy = 1'b0;
            check("rdy_at_load", cmd_rdy, 1'b1);
            tick(P - 11);
        end else begin
            tick(P);
        end
        RX = 1'b1;
        if (!stop_v) tick(2 * P);
    endtask

    task automatic clr_pulse(input logic [15:0] exp_cmd);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("rdy_after_clr", cmd_rdy, 1'b0);
        check("cmd_after_clr", cmd, exp_cmd);
    endtask

    task automatic send_check(input tx_vec_t v, input bit inject);
        int base;
        baud_cnt  = v.baud;
        resp      = v.resp;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        resp      = 8'h00;
        base      = sent_cnt;
        check("tx_busy_set", tx_busy, 1'b1);
        for (int j = 0; j < 10; j++) begin
            check("tx_slot_start", TX, v.exp_frame[j]);
            if (inject && j == 3) begin
                // Request while busy and a baud change mid-frame: both ignored.
                resp      = 8'h55;
                send_resp = 1'b1;
                baud_cnt  = 16'd40;
                tick(1);
                send_resp = 1'b0;
                tick(14);
            end else begin
                tick(15);
            end
            check("tx_slot_end", TX, v.exp_frame[j]);
            if (j == 9) check("resp_sent_early", resp_sent, 1'b0);
            tick(1);
        end
        check("resp_sent_pulse", resp_sent, 1'b1);
        check("tx_busy_clear", tx_busy, 1'b0);
        tick(1);
        check("resp_sent_single", resp_sent, 1'b0);
        check("resp_sent_count", sent_cnt - base, 1);
    endtask

    initial begin
        rxv[0] = '{8'h08, 8'hA5, 16'd16, 16'h08A5};
        rxv[1] = '{8'hFF, 8'h00, 16'd3,  16'hFF00};
        rxv[2] = '{8'h00, 8'hFF, 16'd16, 16'h00FF};
        rxv[3] = '{8'h5A, 8'hC3, 16'd0,  16'h5AC3};

        txv[0] = '{8'hA5, 16'd16, 10'h34A};
        txv[1] = '{8'h00, 16'd5,  10'h200};
        txv[2] = '{8'hFF, 16'd16, 10'h3FE};
        txv[3] = '{8'h3C, 16'd4,  10'h278};

        rst         = 1'b1;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp        = 8'h00;
        baud_cnt    = 16'd16;
        tick(3);
        check("reset_tx", TX, 1'b1);
        check("reset_cmd", cmd, 16'h0000);
        check("reset_cmd_rdy", cmd_rdy, 1'b0);
        check("reset_resp_sent", resp_sent, 1'b0);
        check("reset_tx_busy", tx_busy, 1'b0);
        rst = 1'b0;
        tick(2);

        // Command assembly across several byte pairs and clamped baud values.
        for (int i = 0; i < 4; i++) begin
            baud_cnt = rxv[i].baud;
            send_byte(rxv[i].b0, 1'b1, 1'b0, 1'b0);
            send_byte(rxv[i].b1, 1'b1, 1'b1, 1'b0);
            check("cmd_vec", cmd, rxv[i].exp_cmd);
            clr_pulse(rxv[i].exp_cmd);
        end
        baud_cnt = 16'd16;

        // New HIGH-phase start bit clears a pending cmd_rdy; load beats clear.
        send_byte(8'h10, 1'b1, 1'b0, 1'b0);
        send_byte(8'h20, 1'b1, 1'b1, 1'b0);
        check("cmd_1020", cmd, 16'h1020);
        send_byte(8'h11, 1'b1, 1'b0, 1'b0);
        check("rdy_cleared_by_start", cmd_rdy, 1'b0);
        check("cmd_hold_1020", cmd, 16'h1020);
        send_byte(8'h22, 1'b1, 1'b1, 1'b1);
        check("cmd_1122", cmd, 16'h1122);
        tick(1);
        check("rdy_load_wins", cmd_rdy, 1'b1);
        clr_pulse(16'h1122);

        // Framing error drops the byte and resets phase to HIGH.
        send_byte(8'h99, 1'b1, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0, 1'b0);
        check("rdy_after_frame_err", cmd_rdy, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0, 1'b0);
        send_byte(8'h56, 1'b1, 1'b1, 1'b0);
        check("cmd_3456", cmd, 16'h3456);
        clr_pulse(16'h3456);

        // Quarter-period glitch between the two bytes of a command.
        send_byte(8'h77, 1'b1, 1'b0, 1'b0);
        RX = 1'b0;
        tick(P / 4);
        RX = 1'b1;
        tick(2 * P);
        check("rdy_after_glitch", cmd_rdy, 1'b0);
        check("cmd_after_glitch", cmd, 16'h3456);
        send_byte(8'h88, 1'b1, 1'b1, 1'b0);
        check("cmd_7788", cmd, 16'h7788);
        clr_pulse(16'h7788);

        // Response transmission, including an ignored request mid-frame.
        for (int i = 0; i < 4; i++) begin
            send_check(txv[i], (i == 0));
        end
        baud_cnt = 16'd16;

        // send_resp during the resp_sent cycle is ignored, accepted next cycle.
        resp      = 8'h81;
        send_resp = 1'b1;
        tick(1);
        send_resp = 1'b0;
        tick(159);
        check("b2b_busy_before", tx_busy, 1'b1);
        tick(1);
        check("b2b_resp_sent", resp_sent, 1'b1);
        resp      = 8'hC3;
        send_resp = 1'b1;
        tick(1);
        check("b2b_ignored_busy", tx_busy, 1'b0);
        check("b2b_ignored_tx", TX, 1'b1);
        tick(1);
        send_resp = 1'b0;
        check("b2b_accepted_busy", tx_busy, 1'b1);
        check("b2b_accepted_tx", TX, 1'b0);
        tick(16);
        check("b2b_bit0", TX, 1'b1);
        tick(144);
        check("b2b_resp_sent2", resp_sent, 1'b1);
        tick(1);

        // Full duplex: a response and a command in flight together.
        fork
            send_check(txv[0], 1'b0);
            begin
                tick(7);
                send_byte(8'hDE, 1'b1, 1'b0, 1'b0);
                send_byte(8'hAD, 1'b1, 1'b1, 1'b0);
            end
        join
        check("cmd_dead", cmd, 16'hDEAD);
        clr_pulse(16'hDEAD);

        // Reset during data bit 3 of a response abandons it.
        begin
            int base;
            resp      = 8'hF0;
            send_resp = 1'b1;
            tick(1);
            send_resp = 1'b0;
            base      = sent_cnt;
            tick(70);
            check("mid_tx_low", TX, 1'b0);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            check("rst_mid_tx", TX, 1'b1);
            check("rst_mid_busy", tx_busy, 1'b0);
            check("rst_cmd", cmd, 16'h0000);
            tick(200);
            check("rst_no_resp_sent", sent_cnt - base, 0);
            check("rst_tx_idle", TX, 1'b1);
        end

        // Long gap after a first byte.
        send_byte(8'hAA, 1'b1, 1'b0, 1'b0);
        tick(1200);
        send_byte(8'h01, 1'b1, 1'b0, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0, 1'b0);
        tick(2);
`ifdef CMD_TIMEOUT_EN
        check("timeout_cmd", cmd, 16'h0102);
        check("timeout_rdy", cmd_rdy, 1'b1);
`else
        check("no_timeout_cmd", cmd, 16'hAA01);
        check("no_timeout_rdy", cmd_rdy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
